// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write ports, two read ports, debug read port and ready.
// The master drives addresses/data; the register file is the slave.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            ready;
    logic            we0;
    logic [AW-1:0]   waddr0;
    logic [XLEN-1:0] wdata0;
    logic            we1;
    logic [AW-1:0]   waddr1;
    logic [XLEN-1:0] wdata1;
    logic [AW-1:0]   raddr_a;
    logic [XLEN-1:0] rdata_a;
    logic [AW-1:0]   raddr_b;
    logic [XLEN-1:0] rdata_b;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport master (
        input  ready, rdata_a, rdata_b, dbg_data,
        output we0, waddr0, wdata0, we1, waddr1, wdata1,
        output raddr_a, raddr_b, dbg_addr
    );

    modport slave (
        output ready, rdata_a, rdata_b, dbg_data,
        input  we0, waddr0, wdata0, we1, waddr1, wdata1,
        input  raddr_a, raddr_b, dbg_addr
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two async reads, two prioritised writes, optional
// write-to-read bypass, optional hardwired zero entry, registered debug read, sequenced clear.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t          state, state_next;
    logic [AW-1:0]   idx, idx_next;
    logic            clear_en;
    logic            ready_next;
    logic            ready_p1;
    logic [XLEN-1:0] dbg_data_p1;
    logic [XLEN-1:0] mem [NREGS];

    logic            run;
    logic            wr0_en, wr1_en, wr0_store;
    logic [XLEN-1:0] rd_a, rd_b, rd_dbg;

    // Read-side view of an entry: zero outside RUN, zero register, then bypass (port 1 first).
    function automatic logic [XLEN-1:0] resolve(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored,
        input logic            running,
        input logic            en0,
        input logic [AW-1:0]   a0,
        input logic [XLEN-1:0] d0,
        input logic            en1,
        input logic [AW-1:0]   a1,
        input logic [XLEN-1:0] d1
    );
        if (!running)
            return '0;
        if ((ZERO_REG != 0) && (addr == '0))
            return '0;
        if ((BYPASS != 0) && en1 && (a1 == addr))
            return d1;
        if ((BYPASS != 0) && en0 && (a0 == addr))
            return d0;
        return stored;
    endfunction

    assign run = (state == RUN);

    // Enables already exclude dropped writes to the zero register, so bypass never forwards them.
    assign wr0_en    = run && bus.we0 && !((ZERO_REG != 0) && (bus.waddr0 == '0));
    assign wr1_en    = run && bus.we1 && !((ZERO_REG != 0) && (bus.waddr1 == '0));
    assign wr0_store = wr0_en && !(wr1_en && (bus.waddr1 == bus.waddr0));

    always_comb begin
        state_next = state;
        idx_next   = idx;
        clear_en   = 1'b0;
        case (state)
            INIT: begin
                clear_en = 1'b1;
                if (idx == LAST_IDX)
                    state_next = RUN;
                else
                    idx_next = idx + 1'b1;
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = INIT;
            end
        endcase
        ready_next = (state_next == RUN);
    end

    always_comb begin
        rd_a   = resolve(bus.raddr_a, mem[bus.raddr_a], run,
                         wr0_en, bus.waddr0, bus.wdata0, wr1_en, bus.waddr1, bus.wdata1);
        rd_b   = resolve(bus.raddr_b, mem[bus.raddr_b], run,
                         wr0_en, bus.waddr0, bus.wdata0, wr1_en, bus.waddr1, bus.wdata1);
        rd_dbg = resolve(bus.dbg_addr, mem[bus.dbg_addr], run,
                         wr0_en, bus.waddr0, bus.wdata0, wr1_en, bus.waddr1, bus.wdata1);
    end

    // Control and registered outputs: state, clear index, ready, debug read (p1 stage).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= INIT;
            idx         <= '0;
            ready_p1    <= 1'b0;
            dbg_data_p1 <= '0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            ready_p1    <= ready_next;
            dbg_data_p1 <= rd_dbg;
        end
    end

    // Storage has no reset of its own so it can map onto RAM; the sequencer clears it instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (clear_en) begin
                mem[idx] <= '0;
            end else begin
                if (wr0_store)
                    mem[bus.waddr0] <= bus.wdata0;
                if (wr1_en)
                    mem[bus.waddr1] <= bus.wdata1;
            end
        end
    end

    assign bus.ready    = ready_p1;
    assign bus.rdata_a  = rd_a;
    assign bus.rdata_b  = rd_b;
    assign bus.dbg_data = dbg_data_p1;

endmodule
